// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding memory reads, buffers words for decode.
// Optional saturating perf counters (perf_fetch, perf_stall) are built only when IF_PERF_CNT_EN is defined.
module if_fetch_stage #(
    parameter int ARQ    = 16,
    parameter int AW     = 13,
    parameter int QDEPTH = 2
) (
    input  logic           clk,
    input  logic           rst,
    output logic           mem_req,
    output logic [AW-1:0]  mem_addr,
    input  logic           mem_ack,
    input  logic [ARQ-1:0] mem_rdata,
    output logic [ARQ-1:0] instr,
    output logic [AW-1:0]  instr_pc,
    output logic           instr_valid,
    input  logic           id_ready,
    input  logic           jenable,
    input  logic [AW-1:0]  jaddr
`ifdef IF_PERF_CNT_EN
    ,
    output logic [15:0]    perf_fetch,
    output logic [15:0]    perf_stall
`endif
);

    localparam int PW = $clog2(QDEPTH);
    localparam logic [PW:0] QD = (PW+1)'(QDEPTH);

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_WAIT,
        ST_DISCARD
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic            req_d;
    logic [AW-1:0]   addr_d;
    logic            push, pop;

    logic [PW:0]     wr_ptr, rd_ptr;
    logic [PW:0]     count;
    logic [PW-1:0]   wr_idx, rd_idx;
    logic [ARQ-1:0]  q_data [QDEPTH];
    logic [AW-1:0]   q_pc   [QDEPTH];
    logic [ARQ-1:0]  instr_hold;
    logic [AW-1:0]   pc_hold;

    assign count       = wr_ptr - rd_ptr;
    assign wr_idx      = wr_ptr[PW-1:0];
    assign rd_idx      = rd_ptr[PW-1:0];
    assign instr_valid = (wr_ptr != rd_ptr);
    assign pop         = instr_valid && id_ready && !jenable;

    // When empty the head is undefined, so decode sees the last word it was shown.
    assign instr    = instr_valid ? q_data[rd_idx] : instr_hold;
    assign instr_pc = instr_valid ? q_pc[rd_idx]   : pc_hold;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        req_d   = mem_req;
        addr_d  = mem_addr;
        push    = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (jenable) begin
                    pc_d = jaddr;
                end else if (count < QD) begin
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (jenable) begin
                    pc_d = jaddr;
                    if (mem_ack) begin
                        req_d   = 1'b0;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_DISCARD;
                    end
                end else if (mem_ack) begin
                    push    = 1'b1;
                    pc_d    = pc_q + 1'b1;
                    req_d   = 1'b0;
                    state_d = ST_FETCH;
                end
            end
            ST_DISCARD: begin
                if (jenable) pc_d = jaddr;
                // The stale read completes here whether or not another redirect arrives.
                if (mem_ack) begin
                    req_d   = 1'b0;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_FETCH;
            pc_q     <= '0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            mem_req  <= req_d;
            mem_addr <= addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (jenable) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_data[wr_idx] <= mem_rdata;
            q_pc[wr_idx]   <= pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            instr_hold <= '0;
            pc_hold    <= '0;
        end else begin
            instr_hold <= instr;
            pc_hold    <= instr_pc;
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_fetch <= '0;
            perf_stall <= '0;
        end else begin
            if (push && (perf_fetch != '1))
                perf_fetch <= perf_fetch + 1'b1;
            if (id_ready && !instr_valid && (perf_stall != '1))
                perf_stall <= perf_stall + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed phases plus randomized traffic against a queue-based fetch model.
module tb_if_fetch_stage;

    localparam int ARQ    = 16;
    localparam int AW     = 13;
    localparam int QDEPTH = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           mem_req;
    logic [AW-1:0]  mem_addr;
    logic           mem_ack;
    logic [ARQ-1:0] mem_rdata;
    logic [ARQ-1:0] instr;
    logic [AW-1:0]  instr_pc;
    logic           instr_valid;
    logic           id_ready;
    logic           jenable;
    logic [AW-1:0]  jaddr;
`ifdef IF_PERF_CNT_EN
    logic [15:0]    perf_fetch;
    logic [15:0]    perf_stall;
`endif

    if_fetch_stage #(.ARQ(ARQ), .AW(AW), .QDEPTH(QDEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_valid(instr_valid),
        .id_ready   (id_ready),
        .jenable    (jenable),
        .jaddr      (jaddr)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch (perf_fetch),
        .perf_stall (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // Reference model: PCs in the buffer, next fetch address, outstanding read.
    logic [AW-1:0]  q[$];
    logic [AW-1:0]  seen[$];
    logic [AW-1:0]  exp_fetch;
    logic [AW-1:0]  txn_addr;
    bit             txn_active;
    bit             txn_stale;
    bit             exp_req;
    logic [ARQ-1:0] shown_instr;
    logic [AW-1:0]  shown_pc;
    logic [15:0]    m_fetch;
    logic [15:0]    m_stall;
    int unsigned    n_new;
    int unsigned    n_push;
    int             ack_mode;   // 0 random, 1 always, 2 never

    function automatic logic [ARQ-1:0] mem_word(input logic [AW-1:0] a);
        return {a, a[2:0]} ^ 16'h3C5A;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        exp_fetch   = '0;
        txn_active  = 1'b0;
        txn_stale   = 1'b0;
        exp_req     = 1'b0;
        shown_instr = '0;
        shown_pc    = '0;
        m_fetch     = '0;
        m_stall     = '0;
    endtask

    task automatic check_reset_outputs(input string ph);
        check({ph, "_mem_req"},     mem_req,     0);
        check({ph, "_mem_addr"},    mem_addr,    0);
        check({ph, "_instr"},       instr,       0);
        check({ph, "_instr_pc"},    instr_pc,    0);
        check({ph, "_instr_valid"}, instr_valid, 0);
`ifdef IF_PERF_CNT_EN
        check({ph, "_perf_fetch"},  perf_fetch,  0);
        check({ph, "_perf_stall"},  perf_stall,  0);
`endif
    endtask

    // Called at a negedge: check outputs, drive inputs for the next posedge, advance the model.
    task automatic cycle(input bit rn, input bit rdy, input bit jen, input logic [AW-1:0] ja);
        bit ack;
        check("mem_req", mem_req, exp_req);
        if (mem_req && !txn_active) begin
            check("mem_addr_new", mem_addr, exp_fetch);
            check("fifo_space", q.size() < QDEPTH, 1);
            seen.push_back(mem_addr);
            txn_active = 1'b1;
            txn_stale  = 1'b0;
            txn_addr   = exp_fetch;
            exp_fetch  = exp_fetch + 1'b1;
            n_new++;
        end else if (txn_active) begin
            check("mem_addr_hold", mem_addr, txn_addr);
        end
        check("instr_valid", instr_valid, q.size() > 0);
        if (q.size() > 0) begin
            shown_pc    = q[0];
            shown_instr = mem_word(q[0]);
        end
        check("instr", instr, shown_instr);
        check("instr_pc", instr_pc, shown_pc);
        check("no_dead", instr_valid && (instr == 16'hDEAD), 0);
`ifdef IF_PERF_CNT_EN
        check("perf_fetch", perf_fetch, m_fetch);
        check("perf_stall", perf_stall, m_stall);
`endif

        ack = 1'b0;
        if (txn_active && rn) begin
            case (ack_mode)
                0:       ack = ($urandom_range(0, 1) == 1);
                1:       ack = 1'b1;
                default: ack = 1'b0;
            endcase
        end
        rst      = rn;
        id_ready = rdy;
        jenable  = jen;
        jaddr    = ja;
        mem_ack  = ack;
        if (ack) mem_rdata = txn_stale ? 16'hDEAD : mem_word(txn_addr);
        else     mem_rdata = ARQ'($urandom);

        if (!rn) begin
            model_reset();
        end else begin
            if (rdy && q.size() == 0 && m_stall != 16'hFFFF) m_stall = m_stall + 1'b1;
            if (txn_active) exp_req = !ack;
            else            exp_req = !jen && (q.size() < QDEPTH);
            if (jen) begin
                q.delete();
                exp_fetch = ja;
                if (txn_active) begin
                    if (ack) txn_active = 1'b0;
                    else     txn_stale  = 1'b1;
                end
            end else begin
                if (rdy && q.size() > 0) void'(q.pop_front());
                if (txn_active && ack) begin
                    if (!txn_stale) begin
                        q.push_back(txn_addr);
                        n_push++;
                        if (m_fetch != 16'hFFFF) m_fetch = m_fetch + 1'b1;
                    end
                    txn_active = 1'b0;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned start_size;
        int unsigned start_push;
        bit rdy_r, jen_r;
        logic [AW-1:0] ja_r;

        rst = 1'b0; id_ready = 1'b0; jenable = 1'b0; jaddr = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        n_new = 0; n_push = 0; ack_mode = 1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");

        // Streaming with immediate acks and a ready decoder.
        ack_mode = 1;
        repeat (40) cycle(1, 1, 0, '0);
        check("t1_fetches", n_new, 20);

        // Decoder stalls: buffer fills, requests stop.
        start_size = q.size();
        start_push = n_push;
        repeat (10) cycle(1, 0, 0, '0);
        check("t2_pushes", n_push - start_push, QDEPTH - start_size);
        check("t2_no_req", mem_req, 0);
        check("t2_valid", instr_valid, 1);
        ack_mode = 0;
        repeat (20) cycle(1, 1, 0, '0);

        // Redirect during an outstanding read; stale data must never reach decode.
        ack_mode = 2;
        for (int i = 0; i < 8 && !mem_req; i++) cycle(1, 1, 0, '0);
        check("t3_in_wait", mem_req, 1);
        cycle(1, 1, 1, 13'h0100);
        repeat (2) cycle(1, 1, 0, '0);
        ack_mode = 1;
        cycle(1, 1, 0, '0);
        for (int i = 0; i < 6 && !mem_req; i++) cycle(1, 1, 0, '0);
        check("t3_redirect_addr", mem_addr, 13'h0100);
        repeat (10) cycle(1, 1, 0, '0);

        // PC wraps modulo 2^AW.
        cycle(1, 1, 1, 13'h1FFE);
        seen.delete();
        repeat (12) cycle(1, 1, 0, '0);
        check("t4_count", seen.size() >= 3, 1);
        if (seen.size() >= 3) begin
            check("t4_addr0", seen[0], 13'h1FFE);
            check("t4_addr1", seen[1], 13'h1FFF);
            check("t4_addr2", seen[2], 13'h0000);
        end

        // Reset while a read is outstanding.
        ack_mode = 2;
        for (int i = 0; i < 8 && !mem_req; i++) cycle(1, 1, 0, '0);
        check("t5_in_wait", mem_req, 1);
        cycle(0, 1, 0, '0);
        check_reset_outputs("t5");
        ack_mode = 1;
        cycle(1, 1, 0, '0);
        for (int i = 0; i < 4 && !mem_req; i++) cycle(1, 1, 0, '0);
        check("t5_first_addr", mem_addr, 0);

        // Randomized traffic: random acks, stalls and redirects.
        ack_mode = 0;
        for (int i = 0; i < 400; i++) begin
            rdy_r = ($urandom_range(0, 9) < 7);
            jen_r = ($urandom_range(0, 19) == 0);
            ja_r  = AW'($urandom_range(0, (1 << AW) - 1));
            cycle(1, rdy_r, jen_r, ja_r);
        end

`ifdef IF_PERF_CNT_EN
        // Starve decode long enough to saturate the stall counter.
        cycle(0, 0, 0, '0);
        check_reset_outputs("t6");
        ack_mode = 2;
        repeat (70000) cycle(1, 1, 0, '0);
        check("t6_stall_sat", perf_stall, 16'hFFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
